// File: rtl/scc_isa_pkg.sv
// ISA constants shared by the fetch unit: branch opcodes, condition codes,
// flag bit positions and the condition evaluator used for conditional branches.
package scc_isa_pkg;

    localparam logic [6:0] OP_B     = 7'b1100000;
    localparam logic [6:0] OP_BCOND = 7'b1100001;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    function automatic logic cond_holds(input cond_e cond, input logic [3:0] flags);
        logic n, c, z, v;
        n = flags[FLAG_N];
        c = flags[FLAG_C];
        z = flags[FLAG_Z];
        v = flags[FLAG_V];
        case (cond)
            COND_EQ: return z;
            COND_NE: return !z;
            COND_CS: return c;
            COND_CC: return !c;
            COND_MI: return n;
            COND_PL: return !n;
            COND_VS: return v;
            COND_VC: return !v;
            COND_HI: return c && !z;
            COND_LS: return !(c && !z);
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return !z && (n == v);
            COND_LE: return !(!z && (n == v));
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// Prefetch queue holding {pc, instruction} pairs; flush empties it in one cycle
// and takes priority over a same-cycle push or pop.
module if_prefetch_fifo
    import scc_isa_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         push_pc,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         head_pc,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] pc_mem   [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: it is never observed while the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem[wr_ptr_q]   <= push_pc;
            data_mem[wr_ptr_q] <= push_data;
        end
    end

    assign head_pc   = pc_mem[rd_ptr_q];
    assign head_data = data_mem[rd_ptr_q];
    assign empty     = (count_q == '0);
    assign count     = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: in-order imem reads, prefetch queue, PC-relative branch
// resolution and redirect flushing. Optional counters under IF_PERF_CNT_EN.
module if_fetch_unit
    import scc_isa_pkg::*;
#(
    parameter int unsigned     XLEN            = 32,
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic [3:0]      flags,
    input  logic            flags_valid,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_redirects,
    output logic [31:0]     perf_stalls
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned DW = CW + 4;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [DW-1:0]   drop_q, drop_d;

    logic [XLEN-1:0] head_pc, head_data;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            fifo_push, fifo_pop;

    logic            head_is_b, head_is_bcond, head_stall;
    logic            branch_taken, redirect;
    logic [XLEN-1:0] branch_target;
    logic            resp_drop, resp_live;
    logic [CW:0]     reserved;

    if_prefetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .flush     (redirect),
        .push_pc   (imem_addr_of_resp(pc_q, outstanding_q, drop_q)),
        .push_data (imem_rdata),
        .head_pc   (head_pc),
        .head_data (head_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Responses return in order, so the address of a live response is the oldest
    // live request: pc minus 4 for each live request still in flight.
    function automatic logic [XLEN-1:0] imem_addr_of_resp(input logic [XLEN-1:0] cur_pc,
                                                          input logic [CW-1:0]   live,
                                                          input logic [DW-1:0]   unused_drop);
        logic [XLEN-1:0] back;
        logic            unused;
        unused = ^unused_drop;
        back   = {{(XLEN-CW){1'b0}}, live} << 2;
        return cur_pc - back + {{(XLEN-1){1'b0}}, unused & 1'b0};
    endfunction

    always_comb begin
        head_is_b     = !fifo_empty && (head_data[XLEN-1 -: 7] == OP_B);
        head_is_bcond = !fifo_empty && (head_data[XLEN-1 -: 7] == OP_BCOND);
        head_stall    = head_is_bcond && !flags_valid;

        inst_valid = !fifo_empty && !head_stall && !redirect_valid;
        fifo_pop   = inst_valid && inst_ready;

        branch_target = head_pc + {{(XLEN-16){head_data[15]}}, head_data[15:0]};
        branch_taken  = fifo_pop &&
                        (head_is_b || (head_is_bcond && cond_holds(cond_e'(head_data[24:21]), flags)));
        redirect      = redirect_valid || branch_taken;

        reserved = {1'b0, fifo_count} + {1'b0, outstanding_q};
        imem_req = !reset && !redirect &&
                   (reserved < (CW+1)'(DEPTH)) &&
                   (outstanding_q < CW'(MAX_OUTSTANDING));

        resp_drop = imem_rvalid && (drop_q != '0);
        resp_live = imem_rvalid && (drop_q == '0) && (outstanding_q != '0);
        fifo_push = resp_live && !redirect;
    end

    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (resp_drop) drop_d = drop_q - 1'b1;
        if (resp_live) outstanding_d = outstanding_q - 1'b1;
        if (redirect) begin
            pc_d          = redirect_valid ? redirect_pc : branch_target;
            drop_d        = drop_d + DW'(outstanding_d);
            outstanding_d = '0;
        end else if (imem_req) begin
            pc_d          = pc_q + XLEN'(4);
            outstanding_d = outstanding_d + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign inst_data = fifo_empty ? '0 : head_data;
    assign inst_pc   = fifo_empty ? '0 : head_pc;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_redirects_q, perf_redirects_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;

    always_comb begin
        perf_redirects_d = perf_redirects_q;
        perf_stalls_d    = perf_stalls_q;
        if (branch_taken && (perf_redirects_q != '1)) perf_redirects_d = perf_redirects_q + 1'b1;
        if (head_stall && (perf_stalls_q != '1))      perf_stalls_d    = perf_stalls_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_redirects_q <= '0;
            perf_stalls_q    <= '0;
        end else begin
            perf_redirects_q <= perf_redirects_d;
            perf_stalls_q    <= perf_stalls_d;
        end
    end

    assign perf_redirects = perf_redirects_q;
    assign perf_stalls    = perf_stalls_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed and randomized bench for if_fetch_unit: a program-order model predicts
// every delivered {pc, instruction} from the branch rules and the memory image.
module tb_if_fetch_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXO  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [3:0]  flags;
    logic        flags_valid;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] pc;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_redirects;
    logic [31:0] perf_stalls;
`endif

    if_fetch_unit #(
        .XLEN            (XLEN),
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (RST_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .flags          (flags),
        .flags_valid    (flags_valid),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
`ifdef IF_PERF_CNT_EN
        .perf_redirects (perf_redirects),
        .perf_stalls    (perf_stalls),
`endif
        .pc             (pc)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- program image and ISA reference ----------------
    logic [31:0] prog [logic [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (prog.exists(a)) return prog[a];
        return {8'h00, a[23:0] ^ 24'hA5F00F};
    endfunction

    function automatic logic [31:0] mk_b(input logic [15:0] imm);
        return {7'b1100000, 9'b0, imm};
    endfunction

    function automatic logic [31:0] mk_bc(input logic [3:0] cc, input logic [15:0] imm);
        return {7'b1100001, cc, 5'b0, imm};
    endfunction

    function automatic bit cond_true(input logic [3:0] cc, input logic [3:0] f);
        bit n, c, z, v;
        n = f[3]; c = f[2]; z = f[1]; v = f[0];
        case (cc)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] p, input logic [3:0] f);
        logic [31:0] w, tgt;
        w   = mem_word(p);
        tgt = p + {{16{w[15]}}, w[15:0]};
        if (w[31:25] == 7'b1100000) return tgt;
        if (w[31:25] == 7'b1100001 && cond_true(w[24:21], f)) return tgt;
        return p + 32'd4;
    endfunction

    // ---------------- instruction memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } req_t;

    req_t        mq[$];
    int unsigned cyc = 0;
    int unsigned lat = 1;
    int unsigned last_due = 0;
    int unsigned req_cnt = 0;
    bit          inject_stale = 0;

    always @(negedge clk) begin
        if (imem_req === 1'b1) begin
            req_t r;
            r.addr = imem_addr;
            r.due  = cyc + lat;
            if (mq.size() > 0 && r.due <= last_due) r.due = last_due + 1;
            last_due = r.due;
            mq.push_back(r);
            req_cnt++;
        end
    end

    always @(posedge clk) begin
        cyc++;
        #2;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (inject_stale) begin
            imem_rvalid  = 1'b1;
            imem_rdata   = 32'hDEAD_BEEF;
            inject_stale = 0;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end
    end

    // ---------------- decode-side monitor against the program-order model ----------------
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] got_pc[$];
    int unsigned pops = 0;

    always @(negedge clk) begin
        if (reset) begin
            exp_pc = RST_PC;
        end else if (redirect_valid) begin
            check("ext_redirect_blocks_valid", {31'b0, inst_valid}, 32'd0);
            exp_pc = redirect_pc;
        end else if (inst_valid && inst_ready) begin
            logic [31:0] w;
            w = mem_word(exp_pc);
            check("inst_pc", inst_pc, exp_pc);
            check("inst_data", inst_data, w);
            if (w[31:25] == 7'b1100001) check("bcond_waits_flags", {31'b0, flags_valid}, 32'd1);
            got_pc.push_back(inst_pc);
            pops++;
            exp_pc = next_pc(exp_pc, flags);
        end
    end

    task automatic wait_got(input int unsigned n, input string tag);
        int unsigned k;
        k = 0;
        while (got_pc.size() < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'b0, got_pc.size() >= n}, 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ext_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned lows;
        int unsigned pops0;
        bit          found;

        reset = 1'b1; inst_ready = 1'b0; flags = '0; flags_valid = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; imem_rvalid = 1'b0; imem_rdata = '0;
        prog[32'h10] = mk_b(16'hFFF0);
        prog[32'h20] = mk_bc(4'd0, 16'h0040);

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst_data", inst_data, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_pc", pc, RST_PC);

        // sequential fetch then unconditional backward branch at 0x10
        tick();
        reset = 1'b0; inst_ready = 1'b1; flags_valid = 1'b1;
        got_pc.delete();
        lows = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (imem_req !== 1'b1) lows++;
        end
        check("req_stays_high", lows, 32'd0);
        wait_got(6, "seq_progress");
        check("seq_pc0", got_pc[0], 32'h00);
        check("seq_pc1", got_pc[1], 32'h04);
        check("seq_pc2", got_pc[2], 32'h08);
        check("seq_pc3", got_pc[3], 32'h0C);
        check("b_pc", got_pc[4], 32'h10);
        check("b_target", got_pc[5], 32'h00);

        // conditional EQ at 0x20, flags late, Z set -> taken
        tick();
        flags_valid = 1'b0;
        ext_redirect(32'h20);
        got_pc.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bcond_stall_valid", {31'b0, inst_valid}, 32'd0);
        end
        check("bcond_stall_nopop", got_pc.size(), 32'd0);
        tick();
        flags = 4'b0010; flags_valid = 1'b1;
        @(negedge clk);
        check("bcond_release_valid", {31'b0, inst_valid}, 32'd1);
        check("bcond_release_pc", inst_pc, 32'h20);
        wait_got(2, "bcond_taken_progress");
        check("bcond_taken_target", got_pc[1], 32'h60);

        // same branch, Z clear -> not taken
        tick();
        flags_valid = 1'b0;
        ext_redirect(32'h20);
        got_pc.delete();
        repeat (5) tick();
        flags = 4'b0000; flags_valid = 1'b1;
        wait_got(2, "bcond_nt_progress");
        check("bcond_nt_pc", got_pc[0], 32'h20);
        check("bcond_nt_next", got_pc[1], 32'h24);

        // decode stalled, 3-cycle memory: queue fills to exactly DEPTH
        tick();
        inst_ready = 1'b0; lat = 3;
        ext_redirect(32'h200);
        req_cnt = 0;
        repeat (14) tick();
        @(negedge clk);
        check("full_no_issue", {31'b0, imem_req}, 32'd0);
        check("full_req_count", req_cnt, DEPTH);
        check("full_head_pc", inst_pc, 32'h200);
        tick();
        got_pc.delete();
        inst_ready = 1'b1;
        wait_got(6, "drain_progress");
        for (int i = 0; i < 6; i++) check("drain_order", got_pc[i], 32'h200 + 32'(4 * i));

        // external redirect wins over an unconditional branch at the head
        tick();
        inst_ready = 1'b0; lat = 1;
        ext_redirect(32'h10);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (inst_valid && inst_pc == 32'h10) found = 1;
        end
        check("b_head_reached", {31'b0, found}, 32'd1);
        tick();
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        check("ext_prio_no_pop", {31'b0, inst_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        got_pc.delete();
        wait_got(1, "ext_prio_progress");
        check("ext_prio_target", got_pc[0], 32'h100);

        // reset in the middle of a burst with slow memory
        lat = 3;
        repeat (6) tick();
        reset = 1'b1;
        #1;
        check("mid_rst_pc", pc, RST_PC);
        check("mid_rst_valid", {31'b0, inst_valid}, 32'd0);
        check("mid_rst_req", {31'b0, imem_req}, 32'd0);
        check("mid_rst_inst_pc", inst_pc, 32'd0);
        repeat (6) tick();
        check("rst_hold_valid", {31'b0, inst_valid}, 32'd0);
        reset = 1'b0; inject_stale = 1;
        got_pc.delete();
        wait_got(3, "post_rst_progress");
        check("post_rst_pc0", got_pc[0], 32'h0);
        check("post_rst_pc1", got_pc[1], 32'h4);
        check("post_rst_pc2", got_pc[2], 32'h8);

        // randomized program with branches, back-pressure, late flags, redirects
        for (int unsigned a = 32'h1000; a < 32'h1100; a += 4) begin
            int unsigned r;
            int          off;
            logic [31:0] offv;
            r    = $urandom_range(0, 9);
            off  = ($urandom_range(0, 32) - 16) * 4;
            offv = off;
            if (r == 0) prog[a] = mk_b(offv[15:0]);
            else if (r <= 2) prog[a] = mk_bc(4'($urandom_range(0, 15)), offv[15:0]);
        end
        tick();
        ext_redirect(32'h1000);
        pops0 = pops;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) lat = $urandom_range(1, 4);
            inst_ready  = ($urandom_range(0, 3) != 0);
            flags_valid = ($urandom_range(0, 2) != 0);
            flags       = 4'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h1000 + 32'(4 * $urandom_range(0, 63));
            end else begin
                redirect_valid = 1'b0;
            end
            tick();
        end
        redirect_valid = 1'b0;
        check("random_progress", {31'b0, (pops - pops0) > 200}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
